wt_cache_assoc: RTL and testbench

//  Parametrised N-way set-associative write-through, no-write-allocate cache (word access).

---
 rtl/wt_cache_assoc_pkg.sv | 24 ++
 rtl/wt_cache_assoc_if.sv | 36 +++
 rtl/wt_cache_assoc_way.sv | 54 +++++
 rtl/wt_cache_assoc.sv | 223 ++++++++++++++++++++++
 tb/tb_wt_cache_assoc.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/wt_cache_assoc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wt_cache_assoc_pkg
// Purpose  : Shared widths, memory-command constants and cache FSM states.
// Revision : 1.0  initial release
// ============================================================================
package wt_cache_assoc_pkg;
  localparam int ADDRESS_BITS   = 32;
  localparam int REG_LEN        = 32;
  localparam int CACHE_LINE_LEN = 128;
  localparam int BYTE_LEN       = 8;

  localparam logic MEM_LOAD  = 1'b1;
  localparam logic MEM_STORE = 1'b0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RF_REQ  = 3'd1,
    RF_WAIT = 3'd2,
    WT_REQ  = 3'd3,
    WT_WAIT = 3'd4
  } cache_state_e;
endpackage
`default_nettype wire

// File: rtl/wt_cache_assoc_if.sv
`default_nettype none
// ============================================================================
// Module   : wt_cache_assoc_if
// Purpose  : Core access port plus memory-arbiter port of the cache.
// Revision : 1.0  initial release
// ============================================================================
interface wt_cache_assoc_if;
  import wt_cache_assoc_pkg::*;

  logic                      req;
  logic                      store;
  logic [ADDRESS_BITS-1:0]   addr;
  logic [REG_LEN-1:0]        in_data;
  logic                      hit;
  logic                      stall;
  logic [REG_LEN-1:0]        out_data;
  logic                      mem_req;
  logic                      mem_instr;
  logic [ADDRESS_BITS-1:0]   mem_addr;
  logic [REG_LEN-1:0]        mem_wdata;
  logic                      grant;
  logic                      mem_resp;
  logic [CACHE_LINE_LEN-1:0] fill;

  // slave = the cache itself; master = the core and memory system around it
  modport slave (
    input  req, store, addr, in_data, grant, mem_resp, fill,
    output hit, stall, out_data, mem_req, mem_instr, mem_addr, mem_wdata
  );

  modport master (
    output req, store, addr, in_data, grant, mem_resp, fill,
    input  hit, stall, out_data, mem_req, mem_instr, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/wt_cache_assoc_way.sv
`default_nettype none
// ============================================================================
// Module   : wt_cache_assoc_way
// Purpose  : One cache way: per-set valid bit, tag and line storage.
// Revision : 1.0  initial release
// ============================================================================
module wt_cache_assoc_way #(
  parameter int N_SETS   = 4,
  parameter int IDX_W    = 2,
  parameter int TAG_BITS = 26,
  parameter int LINE_LEN = 128,
  parameter int WORD_LEN = 32,
  parameter int WSEL_W   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_W-1:0]    i_index,
  input  logic                i_fill_we,
  input  logic [TAG_BITS-1:0] i_fill_tag,
  input  logic [LINE_LEN-1:0] i_fill_line,
  input  logic                i_word_we,
  input  logic [WSEL_W-1:0]   i_word_sel,
  input  logic [WORD_LEN-1:0] i_word_data,
  output logic                o_valid,
  output logic [TAG_BITS-1:0] o_tag,
  output logic [LINE_LEN-1:0] o_line
);
  logic [N_SETS-1:0]   r_valid;
  logic [TAG_BITS-1:0] r_tag  [N_SETS];
  logic [LINE_LEN-1:0] r_line [N_SETS];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_fill_we) begin
      r_valid[i_index] <= 1'b1;
    end
  end

  // Tag and data need no reset: they are qualified by the valid bit
  always_ff @(posedge clk) begin
    if (i_fill_we) begin
      r_tag[i_index]  <= i_fill_tag;
      r_line[i_index] <= i_fill_line;
    end else if (i_word_we) begin
      r_line[i_index][i_word_sel*WORD_LEN +: WORD_LEN] <= i_word_data;
    end
  end

  assign o_valid = r_valid[i_index];
  assign o_tag   = r_tag[i_index];
  assign o_line  = r_line[i_index];
endmodule
`default_nettype wire

// File: rtl/wt_cache_assoc.sv
`default_nettype none
// ============================================================================
// Module   : wt_cache_assoc
// Purpose  : N-way set-associative write-through, no-write-allocate cache.
// Revision : 1.0  initial release
// ============================================================================
module wt_cache_assoc
  import wt_cache_assoc_pkg::*;
#(
  parameter int N_SETS = 4,
  parameter int N_WAYS = 2
) (
  input logic             clk,
  input logic             rst,
  wt_cache_assoc_if.slave cache_bus
);
  localparam int INDEX_BITS = (N_SETS > 1) ? $clog2(N_SETS) : 0;
  localparam int IDX_W      = (INDEX_BITS > 0) ? INDEX_BITS : 1;
  localparam int OFF_BITS   = $clog2(CACHE_LINE_LEN / BYTE_LEN);
  localparam int WORD_OFF   = $clog2(REG_LEN / BYTE_LEN);
  localparam int WSEL_W     = OFF_BITS - WORD_OFF;
  localparam int TAG_BITS   = ADDRESS_BITS - OFF_BITS - INDEX_BITS;
  localparam int WAY_W      = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;

  cache_state_e              r_state;
  cache_state_e              w_state_nxt;
  logic                      r_mem_req;
  logic                      r_mem_instr;
  logic [ADDRESS_BITS-1:0]   r_mem_addr;
  logic [REG_LEN-1:0]        r_mem_wdata;
  logic [WAY_W-1:0]          r_rr [N_SETS];

  logic [ADDRESS_BITS-1:0]   w_lk_addr;
  logic [IDX_W-1:0]          w_idx;
  logic [TAG_BITS-1:0]       w_tag;
  logic [WSEL_W-1:0]         w_wsel;
  logic [N_WAYS-1:0]         w_match;
  logic [N_WAYS-1:0]         w_victim;
  logic [CACHE_LINE_LEN-1:0] w_way_line [N_WAYS];
  logic [CACHE_LINE_LEN-1:0] w_hit_line;
  logic                      w_any_hit;
  logic [REG_LEN-1:0]        w_hit_word;
  logic                      w_hit;
  logic                      w_stall;
  logic [REG_LEN-1:0]        w_out_data;
  logic                      w_fill_we;
  logic                      w_word_we;
  logic                      w_start_rf;
  logic                      w_start_wt;
  logic                      w_granted;
  logic                      w_unused_low;

  // Outside IDLE the set/tag come from the latched request, not the core bus
  assign w_lk_addr    = (r_state == IDLE) ? cache_bus.addr : r_mem_addr;
  assign w_tag        = w_lk_addr[ADDRESS_BITS-1 -: TAG_BITS];
  assign w_wsel       = w_lk_addr[OFF_BITS-1:WORD_OFF];
  assign w_unused_low = ^w_lk_addr[WORD_OFF-1:0];

  generate
    if (INDEX_BITS > 0) begin : g_index
      assign w_idx = w_lk_addr[OFF_BITS +: INDEX_BITS];
    end else begin : g_no_index
      assign w_idx = '0;
    end
  endgenerate

  generate
    for (genvar g = 0; g < N_WAYS; g++) begin : g_way
      logic                w_valid;
      logic [TAG_BITS-1:0] w_way_tag;

      assign w_victim[g] = (r_rr[w_idx] == WAY_W'(g));

      wt_cache_assoc_way #(
        .N_SETS   (N_SETS),
        .IDX_W    (IDX_W),
        .TAG_BITS (TAG_BITS),
        .LINE_LEN (CACHE_LINE_LEN),
        .WORD_LEN (REG_LEN),
        .WSEL_W   (WSEL_W)
      ) u_way (
        .clk         (clk),
        .rst         (rst),
        .i_index     (w_idx),
        .i_fill_we   (w_fill_we & w_victim[g]),
        .i_fill_tag  (w_tag),
        .i_fill_line (cache_bus.fill),
        .i_word_we   (w_word_we & w_match[g]),
        .i_word_sel  (w_wsel),
        .i_word_data (cache_bus.in_data),
        .o_valid     (w_valid),
        .o_tag       (w_way_tag),
        .o_line      (w_way_line[g])
      );

      assign w_match[g] = w_valid && (w_way_tag == w_tag);
    end
  endgenerate

  always_comb begin
    w_hit_line = '0;
    for (int i = 0; i < N_WAYS; i++) begin
      if (w_match[i]) w_hit_line = w_hit_line | w_way_line[i];
    end
  end

  assign w_any_hit  = |w_match;
  assign w_hit_word = w_hit_line[w_wsel*REG_LEN +: REG_LEN];

  always_comb begin
    w_state_nxt = r_state;
    w_hit       = 1'b0;
    w_stall     = 1'b0;
    w_out_data  = '0;
    w_fill_we   = 1'b0;
    w_word_we   = 1'b0;
    w_start_rf  = 1'b0;
    w_start_wt  = 1'b0;
    w_granted   = 1'b0;
    case (r_state)
      IDLE: begin
        if (cache_bus.req) begin
          if (cache_bus.store) begin
            // Hit line is patched here, once; completion only reports hit
            w_word_we   = w_any_hit;
            w_start_wt  = 1'b1;
            w_stall     = 1'b1;
            w_state_nxt = WT_REQ;
          end else if (w_any_hit) begin
            w_hit      = 1'b1;
            w_out_data = w_hit_word;
          end else begin
            w_start_rf  = 1'b1;
            w_stall     = 1'b1;
            w_state_nxt = RF_REQ;
          end
        end
      end
      RF_REQ: begin
        w_stall = 1'b1;
        if (cache_bus.grant) begin
          w_granted = 1'b1;
          if (cache_bus.mem_resp) begin
            w_fill_we   = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = RF_WAIT;
          end
        end
      end
      RF_WAIT: begin
        w_stall = 1'b1;
        if (cache_bus.mem_resp) begin
          w_fill_we   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      WT_REQ: begin
        if (cache_bus.grant) begin
          w_granted = 1'b1;
        end
        if (cache_bus.grant && cache_bus.mem_resp) begin
          w_hit       = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_stall = 1'b1;
          if (cache_bus.grant) w_state_nxt = WT_WAIT;
        end
      end
      WT_WAIT: begin
        if (cache_bus.mem_resp) begin
          w_hit       = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_req   <= 1'b0;
      r_mem_instr <= MEM_LOAD;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_start_rf) begin
      r_mem_req   <= 1'b1;
      r_mem_instr <= MEM_LOAD;
      r_mem_addr  <= {cache_bus.addr[ADDRESS_BITS-1:OFF_BITS], {OFF_BITS{1'b0}}};
    end else if (w_start_wt) begin
      r_mem_req   <= 1'b1;
      r_mem_instr <= MEM_STORE;
      r_mem_addr  <= cache_bus.addr;
      r_mem_wdata <= cache_bus.in_data;
    end else if (w_granted) begin
      r_mem_req <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_SETS; i++) r_rr[i] <= '0;
    end else if (w_fill_we) begin
      r_rr[w_idx] <= (r_rr[w_idx] == WAY_W'(N_WAYS - 1)) ? '0 : r_rr[w_idx] + WAY_W'(1);
    end
  end

  assign cache_bus.hit       = w_hit;
  assign cache_bus.stall     = w_stall;
  assign cache_bus.out_data  = w_out_data;
  assign cache_bus.mem_req   = r_mem_req;
  assign cache_bus.mem_instr = r_mem_instr;
  assign cache_bus.mem_addr  = r_mem_addr;
  assign cache_bus.mem_wdata = r_mem_wdata;
endmodule
`default_nettype wire

// File: tb/tb_wt_cache_assoc.sv
`default_nettype none
// ============================================================================
// Module   : tb_wt_cache_assoc
// Purpose  : Directed and randomized accesses against a line-level cache model.
// Revision : 1.0  initial release
// ============================================================================
module tb_wt_cache_assoc;
  import wt_cache_assoc_pkg::*;

  localparam int NS  = 4;
  localparam int NW  = 2;
  localparam int LB  = CACHE_LINE_LEN / BYTE_LEN;
  localparam int WPL = CACHE_LINE_LEN / REG_LEN;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wt_cache_assoc_if bus_if();

  wt_cache_assoc #(.N_SETS(NS), .N_WAYS(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cache_bus (bus_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  bit          m_valid [NW][NS];
  int unsigned m_line  [NW][NS];
  logic [31:0] m_data  [NW][NS][WPL];
  int          m_rr    [NS];
  logic [31:0] mem_img [logic [31:0]];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic int set_of(input logic [31:0] a);
    return int'((a / LB) % NS);
  endfunction

  function automatic int m_find(input logic [31:0] a);
    int s = set_of(a);
    for (int w = 0; w < NW; w++)
      if (m_valid[w][s] && m_line[w][s] == a / LB) return w;
    return -1;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < NS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < NW; w++) m_valid[w][s] = 1'b0;
    end
  endtask

  task automatic idle_bus();
    bus_if.req = 1'b0; bus_if.store = 1'b0; bus_if.addr = '0; bus_if.in_data = '0;
    bus_if.grant = 1'b0; bus_if.mem_resp = 1'b0; bus_if.fill = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_bus();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  // One core access; g = cycles before grant, d = cycles from grant to resp
  task automatic do_access(input bit st, input logic [31:0] a, input logic [31:0] din,
                           input int g, input int d);
    int w  = m_find(a);
    int s  = set_of(a);
    int wi = int'((a % LB) / 4);
    int v;
    logic [31:0] la = a - (a % LB);
    logic [CACHE_LINE_LEN-1:0] line;
    for (int k = 0; k < WPL; k++) line[k*32 +: 32] = mem_rd(la + 32'(4*k));

    @(negedge clk);
    bus_if.req = 1'b1; bus_if.store = st; bus_if.addr = a; bus_if.in_data = din;
    #1;
    if (!st && w >= 0) begin
      check("ld_hit", bus_if.hit, 1);
      check("ld_data", bus_if.out_data, m_data[w][s][wi]);
      check("ld_stall", bus_if.stall, 0);
    end else begin
      check("acc_hit", bus_if.hit, 0);
      check("acc_stall", bus_if.stall, 1);
      for (int c = 0; c <= g; c++) begin
        @(negedge clk);
        bus_if.grant = (c == g); bus_if.mem_resp = (c == g && d == 0); bus_if.fill = line;
        #1;
        check("req_mreq", bus_if.mem_req, 1);
        check("req_instr", bus_if.mem_instr, st ? 0 : 1);
        check("req_addr", bus_if.mem_addr, st ? a : la);
        if (st) check("req_wdata", bus_if.mem_wdata, din);
        if (c == g && d == 0 && st) begin
          check("req_done_hit", bus_if.hit, 1);
          check("req_done_stall", bus_if.stall, 0);
        end else begin
          check("req_stall", bus_if.stall, 1);
        end
      end
      for (int c = 1; c <= d; c++) begin
        @(negedge clk);
        bus_if.grant = 1'b0; bus_if.mem_resp = (c == d);
        #1;
        check("wait_mreq", bus_if.mem_req, 0);
        if (c == d && st) begin
          check("wait_done_hit", bus_if.hit, 1);
          check("wait_done_stall", bus_if.stall, 0);
          check("wait_done_out", bus_if.out_data, 0);
        end else begin
          check("wait_stall", bus_if.stall, 1);
        end
      end
      if (st) begin
        mem_img[a] = din;
        if (w >= 0) m_data[w][s][wi] = din;
      end else begin
        v = m_rr[s];
        m_valid[v][s] = 1'b1;
        m_line[v][s]  = a / LB;
        for (int k = 0; k < WPL; k++) m_data[v][s][k] = line[k*32 +: 32];
        m_rr[s] = (v + 1) % NW;
      end
      @(negedge clk);
      bus_if.grant = 1'b0; bus_if.mem_resp = 1'b0;
      if (st) bus_if.req = 1'b0;
      #1;
      check("post_mreq", bus_if.mem_req, 0);
      if (st) begin
        check("post_st_hit", bus_if.hit, 0);
        check("post_st_stall", bus_if.stall, 0);
      end else begin
        check("refill_hit", bus_if.hit, 1);
        check("refill_data", bus_if.out_data, m_data[m_find(a) < 0 ? 0 : m_find(a)][s][wi]);
        check("refill_stall", bus_if.stall, 0);
      end
    end
    @(negedge clk);
    bus_if.req = 1'b0; bus_if.store = 1'b0;
  endtask

  task automatic rst_mid_refill(input logic [31:0] a);
    @(negedge clk);
    bus_if.req = 1'b1; bus_if.store = 1'b0; bus_if.addr = a;
    @(negedge clk);
    bus_if.grant = 1'b1;
    #1 check("mr_mreq", bus_if.mem_req, 1);
    @(negedge clk);
    bus_if.grant = 1'b0;
    #1 check("mr_wait_stall", bus_if.stall, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus_if.req = 1'b0;
    #1;
    check("mr_rst_mreq", bus_if.mem_req, 0);
    check("mr_rst_stall", bus_if.stall, 0);
    @(negedge clk);
    bus_if.mem_resp = 1'b1; bus_if.fill = '1;
    #1;
    check("mr_late_hit", bus_if.hit, 0);
    check("mr_late_stall", bus_if.stall, 0);
    @(negedge clk);
    bus_if.mem_resp = 1'b0;
    model_clear();
    do_access(1'b0, a, 32'h0, 1, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    rst = 1'b1;
    idle_bus();
    do_reset();
    #1;
    check("rst_hit", bus_if.hit, 0);
    check("rst_stall", bus_if.stall, 0);
    check("rst_mreq", bus_if.mem_req, 0);
    check("rst_instr", bus_if.mem_instr, 1);
    check("rst_maddr", bus_if.mem_addr, 0);
    check("rst_wdata", bus_if.mem_wdata, 0);
    check("rst_out", bus_if.out_data, 0);

    mem_img[32'h104] = 32'hCAFE_0001;
    do_access(1'b0, 32'h100, 0, 0, 1);
    do_access(1'b0, 32'h104, 0, 0, 0);

    do_reset();
    do_access(1'b0, 32'h000, 0, 1, 2);
    do_access(1'b0, 32'h040, 0, 0, 1);
    do_access(1'b0, 32'h080, 0, 2, 0);
    do_access(1'b0, 32'h040, 0, 0, 0);
    do_access(1'b0, 32'h000, 0, 0, 1);

    do_access(1'b0, 32'h100, 0, 0, 1);
    do_access(1'b1, 32'h104, 32'h1234_5678, 1, 1);
    do_access(1'b0, 32'h104, 0, 0, 0);

    do_access(1'b1, 32'h200, 32'hA5A5_0200, 0, 2);
    do_access(1'b0, 32'h200, 0, 0, 1);

    do_access(1'b0, 32'h300, 0, 5, 0);
    do_access(1'b1, 32'h304, 32'h0BAD_F00D, 5, 0);
    do_access(1'b0, 32'h304, 0, 0, 0);

    rst_mid_refill(32'h400);

    for (int i = 0; i < 200; i++) begin
      ra = ($urandom_range(0, 15) << 4) | ($urandom_range(0, 3) << 2);
      do_access($urandom_range(0, 9) < 3, ra, $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
